// File: rtl/ahb_lite_pkg.sv
// Shared AHB-lite encodings and data-phase state type for the AHB-to-SRAM bridge.
// Includes the address-phase legality check used when a transfer is accepted.
package ahb_lite_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HSIZE_BYTE = 3'd0;
    localparam logic [2:0] HSIZE_HALF = 3'd1;
    localparam logic [2:0] HSIZE_WORD = 3'd2;

    typedef enum logic [2:0] {
        DP_IDLE,
        DP_READ,
        DP_WRITE,
        DP_STALL,
        DP_ERR1,
        DP_ERR2
    } dp_state_t;

    // Unsupported sizes and misaligned half/word accesses are answered with ERROR.
    function automatic logic xfer_error(input logic [2:0] size, input logic [1:0] lsb);
        logic err;
        err = 1'b0;
        if (size > HSIZE_WORD) begin
            err = 1'b1;
        end else if (size == HSIZE_HALF && lsb[0]) begin
            err = 1'b1;
        end else if (size == HSIZE_WORD && lsb != 2'b00) begin
            err = 1'b1;
        end
        return err;
    endfunction

endpackage

// File: rtl/ahb_byte_lane_merge.sv
// Little-endian byte-lane merge: replaces the lanes addressed by a byte or
// halfword transfer inside the old SRAM word; a word transfer takes the new word.
module ahb_byte_lane_merge
    import ahb_lite_pkg::*;
(
    input  logic [31:0] old_word,
    input  logic [31:0] new_word,
    input  logic [1:0]  addr,
    input  logic [2:0]  size,
    output logic [31:0] merged
);

    logic [3:0] lane_en;

    always_comb begin
        lane_en = 4'b0000;
        case (size)
            HSIZE_BYTE: lane_en = 4'b0001 << addr;
            HSIZE_HALF: lane_en = addr[1] ? 4'b1100 : 4'b0011;
            default:    lane_en = 4'b1111;
        endcase
    end

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign merged[8*gi +: 8] = lane_en[gi] ? new_word[8*gi +: 8] : old_word[8*gi +: 8];
        end
    endgenerate

endmodule

// File: rtl/ahb_sram_bridge.sv
// AHB-lite slave driving a single-port synchronous SRAM (registered read address).
// Sub-word writes are read-merge-write; a read or sub-word write following a write costs one wait.
module ahb_sram_bridge
    import ahb_lite_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              HSEL,
    input  logic [31:0]       HADDR,
    input  logic [1:0]        HTRANS,
    input  logic              HWRITE,
    input  logic [2:0]        HSIZE,
    input  logic              HREADY,
    input  logic [31:0]       HWDATA,
    output logic [31:0]       HRDATA,
    output logic              HREADYOUT,
    output logic              HRESP,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [31:0]       sram_data,
    output logic              sram_wren,
    input  logic [31:0]       sram_q
);

    dp_state_t         state_reg, state_next;
    logic [ADDR_W+1:0] aph_addr_reg, aph_addr_next;
    logic              aph_write_reg, aph_write_next;
    logic [2:0]        aph_size_reg, aph_size_next;

    logic accept;
    logic addr_err;
    logic use_aph_addr;
    logic write_phase;
    logic unused_bits;

    assign accept      = HSEL & HREADY & HTRANS[1];
    assign addr_err    = xfer_error(HSIZE, HADDR[1:0]);
    assign unused_bits = ^{HADDR[31:ADDR_W+2], HTRANS[0]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= DP_IDLE;
            aph_addr_reg  <= '0;
            aph_write_reg <= 1'b0;
            aph_size_reg  <= 3'd0;
        end else begin
            state_reg     <= state_next;
            aph_addr_reg  <= aph_addr_next;
            aph_write_reg <= aph_write_next;
            aph_size_reg  <= aph_size_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        aph_addr_next  = aph_addr_reg;
        aph_write_next = aph_write_reg;
        aph_size_next  = aph_size_reg;
        HREADYOUT      = 1'b1;
        HRESP          = 1'b0;
        use_aph_addr   = 1'b0;
        write_phase    = 1'b0;

        case (state_reg)
            DP_WRITE: begin
                use_aph_addr = 1'b1;
                write_phase  = 1'b1;
            end
            DP_STALL: begin
                use_aph_addr = 1'b1;
                HREADYOUT    = 1'b0;
            end
            DP_ERR1: begin
                HREADYOUT = 1'b0;
                HRESP     = 1'b1;
            end
            DP_ERR2: begin
                HRESP = 1'b1;
            end
            default: ;
        endcase

        if (state_reg == DP_STALL) begin
            state_next = aph_write_reg ? DP_WRITE : DP_READ;
        end else if (state_reg == DP_ERR1) begin
            state_next = DP_ERR2;
        end else if (accept) begin
            aph_addr_next  = HADDR[ADDR_W+1:0];
            aph_write_next = HWRITE;
            aph_size_next  = HSIZE;
            if (addr_err) begin
                state_next = DP_ERR1;
            end else if (state_reg == DP_WRITE && (!HWRITE || HSIZE != HSIZE_WORD)) begin
                // The SRAM port is busy with the write, so the new address is presented next cycle.
                state_next = DP_STALL;
            end else if (HWRITE) begin
                state_next = DP_WRITE;
            end else begin
                state_next = DP_READ;
            end
        end else begin
            state_next = DP_IDLE;
        end
    end

    assign sram_addr = use_aph_addr ? aph_addr_reg[ADDR_W+1:2] : HADDR[ADDR_W+1:2];
    // A reset arriving during a write data phase must not disturb memory.
    assign sram_wren = write_phase & ~rst;
    assign HRDATA    = sram_q;

    ahb_byte_lane_merge u_merge (
        .old_word (sram_q),
        .new_word (HWDATA),
        .addr     (aph_addr_reg[1:0]),
        .size     (aph_size_reg),
        .merged   (sram_data)
    );

endmodule
